// File: rtl/fcpu_pkg.sv
// Shared AXI constants and state encodings for the UART bridge.
package fcpu_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_LAST,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with registered occupancy count.
// dout always shows the head entry; there is no bypass from din to dout.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-2 depth; count tracks push/pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_axi_uart_bridge.sv
// AXI4 slave bridging the CPU io port to the UART byte streams.
// Writes: one TX byte per W beat, B after the final byte leaves.
// Reads: single-beat, each pops one byte from the RX FIFO.
module io_axi_uart_bridge #(
  parameter int ID_W     = 4,
  parameter int RX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [ID_W-1:0]             io_awid,
  input  logic                        io_awvalid,
  output logic                        io_awready,
  input  logic [7:0]                  io_wdata,
  input  logic                        io_wlast,
  input  logic                        io_wvalid,
  output logic                        io_wready,
  output logic [ID_W-1:0]             io_bid,
  output logic [1:0]                  io_bresp,
  output logic                        io_bvalid,
  input  logic                        io_bready,
  input  logic [ID_W-1:0]             io_arid,
  input  logic                        io_arvalid,
  output logic                        io_arready,
  output logic [ID_W-1:0]             io_rid,
  output logic [7:0]                  io_rdata,
  output logic [1:0]                  io_rresp,
  output logic                        io_rlast,
  output logic                        io_rvalid,
  input  logic                        io_rready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count
);

  import fcpu_pkg::*;

  wr_state_t       r_wr_state, w_wr_next;
  rd_state_t       r_rd_state, w_rd_next;
  logic [ID_W-1:0] r_bid;
  logic [ID_W-1:0] r_rid;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic [7:0]      r_rdata;
  logic            w_awready, w_wready, w_bvalid;
  logic            w_arready, w_rvalid;
  logic            w_w_hs, w_tx_hs;
  logic            w_fifo_pop, w_fifo_full, w_fifo_empty;
  logic [7:0]      w_fifo_dout;

  assign w_w_hs  = io_wvalid && w_wready;
  assign w_tx_hs = r_tx_valid && tx_ready;

  // Write FSM next state and handshake outputs.
  always_comb begin
    w_wr_next = r_wr_state;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        w_awready = 1'b1;
        if (io_awvalid) w_wr_next = W_DATA;
      end
      W_DATA: begin
        w_wready = !r_tx_valid;
        if (io_wvalid && !r_tx_valid && io_wlast) w_wr_next = W_LAST;
      end
      W_LAST: begin
        if (w_tx_hs) w_wr_next = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (io_bready) w_wr_next = W_IDLE;
      end
    endcase
  end

  // Write state, captured ID and the TX output register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_state <= W_IDLE;
      r_bid      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      if (io_awvalid && w_awready) r_bid <= io_awid;
      if (w_w_hs) begin
        r_tx_data  <= io_wdata;
        r_tx_valid <= 1'b1;
      end else if (w_tx_hs) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  // Read FSM next state and handshake outputs; pop only while waiting.
  always_comb begin
    w_rd_next  = r_rd_state;
    w_arready  = 1'b0;
    w_rvalid   = 1'b0;
    w_fifo_pop = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        w_arready = 1'b1;
        if (io_arvalid) w_rd_next = R_WAIT;
      end
      R_WAIT: begin
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          w_rd_next  = R_RESP;
        end
      end
      R_RESP: begin
        w_rvalid = 1'b1;
        if (io_rready) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Read state, captured ID and the registered read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_state <= R_IDLE;
      r_rid      <= '0;
      r_rdata    <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (io_arvalid && w_arready) r_rid <= io_arid;
      if (w_fifo_pop) r_rdata <= w_fifo_dout;
    end
  end

  sync_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (rx_valid && rx_ready),
    .din   (rx_data),
    .pop   (w_fifo_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (rx_count)
  );

  assign io_awready = w_awready;
  assign io_wready  = w_wready;
  assign io_bvalid  = w_bvalid;
  assign io_bid     = r_bid;
  assign io_bresp   = AXI_RESP_OKAY;
  assign io_arready = w_arready;
  assign io_rvalid  = w_rvalid;
  assign io_rid     = r_rid;
  assign io_rdata   = r_rdata;
  assign io_rresp   = AXI_RESP_OKAY;
  assign io_rlast   = 1'b1;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign rx_ready   = !w_fifo_full;

endmodule

// File: tb/tb_io_axi_uart_bridge.sv
// Directed bench for io_axi_uart_bridge: inputs driven and outputs sampled on negedges.
module tb_io_axi_uart_bridge;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] io_awid, io_bid, io_arid, io_rid;
  logic       io_awvalid, io_awready;
  logic [7:0] io_wdata;
  logic       io_wlast, io_wvalid, io_wready;
  logic [1:0] io_bresp, io_rresp;
  logic       io_bvalid, io_bready;
  logic       io_arvalid, io_arready;
  logic [7:0] io_rdata;
  logic       io_rlast, io_rvalid, io_rready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [4:0] rx_count;

  int n_chk  = 0;
  int n_pass = 0;

  io_axi_uart_bridge #(.ID_W(4), .RX_DEPTH(16)) dut (
    .clk(clk), .nrst(nrst),
    .io_awid(io_awid), .io_awvalid(io_awvalid), .io_awready(io_awready),
    .io_wdata(io_wdata), .io_wlast(io_wlast), .io_wvalid(io_wvalid), .io_wready(io_wready),
    .io_bid(io_bid), .io_bresp(io_bresp), .io_bvalid(io_bvalid), .io_bready(io_bready),
    .io_arid(io_arid), .io_arvalid(io_arvalid), .io_arready(io_arready),
    .io_rid(io_rid), .io_rdata(io_rdata), .io_rresp(io_rresp), .io_rlast(io_rlast),
    .io_rvalid(io_rvalid), .io_rready(io_rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(negedge clk); rx_valid = 1'b1; rx_data = d;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  // One read transaction; optionally injects an RX byte in the pop cycle.
  task automatic do_read(input logic [3:0] id, input bit inj, input logic [7:0] inj_d,
                         output logic [7:0] d, output logic [3:0] rid, output logic rl,
                         output bit ok);
    int n;
    @(negedge clk); io_arid = id; io_arvalid = 1'b1;
    n = 0;
    while (!io_arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); io_arvalid = 1'b0;
    if (inj) begin
      rx_valid = 1'b1; rx_data = inj_d;
      @(negedge clk); rx_valid = 1'b0;
    end
    n = 0;
    while (!io_rvalid && n < 50) begin @(negedge clk); n++; end
    ok = io_rvalid; d = io_rdata; rid = io_rid; rl = io_rlast;
    io_rready = 1'b1;
    @(negedge clk); io_rready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [3:0] rid;
    logic       rl;
    bit         ok;
    int         n;
    int         extra_b;
    bit         early;
    logic [7:0] held;

    nrst = 1'b0;
    io_awid = '0; io_awvalid = 0; io_wdata = '0; io_wlast = 0; io_wvalid = 0;
    io_bready = 0; io_arid = '0; io_arvalid = 0; io_rready = 0;
    tx_ready = 0; rx_data = '0; rx_valid = 0;

    // Reset state
    #12;
    chk("rst_txv", tx_valid, 0);
    chk("rst_bvalid", io_bvalid, 0);
    chk("rst_rvalid", io_rvalid, 0);
    chk("rst_rlast", io_rlast, 1);
    chk("rst_count", rx_count, 0);
    @(negedge clk); nrst = 1'b1;

    // Single write
    @(negedge clk); io_awid = 4'd3; io_awvalid = 1; tx_ready = 1;
    chk("t1_awready", io_awready, 1);
    @(negedge clk); io_awvalid = 0; io_wdata = 8'h41; io_wlast = 1; io_wvalid = 1;
    chk("t1_wready", io_wready, 1);
    @(negedge clk); io_wvalid = 0; io_wlast = 0;
    chk("t1_txv", tx_valid, 1);
    chk("t1_txd", tx_data, 8'h41);
    chk("t1_no_early_b", io_bvalid, 0);
    @(negedge clk);
    chk("t1_txv_clr", tx_valid, 0);
    chk("t1_bvalid", io_bvalid, 1);
    chk("t1_bid", io_bid, 4'd3);
    chk("t1_bresp", io_bresp, 2'b00);
    io_bready = 1;
    @(negedge clk); io_bready = 0; tx_ready = 0;
    chk("t1_b_done", io_bvalid, 0);

    // Burst write with TX backpressure
    @(negedge clk); io_awid = 4'd6; io_awvalid = 1;
    @(negedge clk); io_awvalid = 0;
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!io_wready && n < 20) begin @(negedge clk); n++; end
      chk("t2_wready", io_wready, 1);
      held = 8'(8'h60 + b);
      io_wdata = held; io_wlast = (b == 2); io_wvalid = 1;
      @(negedge clk); io_wvalid = 0; io_wlast = 0;
      for (int s = 0; s < 5; s++) begin
        chk("t2_txv_hold", tx_valid, 1);
        chk("t2_txd_stable", tx_data, held);
        chk("t2_wready_low", io_wready, 0);
        chk("t2_no_early_b", io_bvalid, 0);
        @(negedge clk);
      end
      tx_ready = 1;
      @(negedge clk); tx_ready = 0;
      chk("t2_txv_clr", tx_valid, 0);
    end
    chk("t2_bvalid", io_bvalid, 1);
    chk("t2_bid", io_bid, 4'd6);
    io_bready = 1;
    @(negedge clk); io_bready = 0;
    extra_b = 0;
    for (int i = 0; i < 5; i++) begin
      if (io_bvalid) extra_b++;
      @(negedge clk);
    end
    chk("t2_one_b", extra_b, 0);

    // Read after RX, including a push in the same cycle as a pop
    rx_push(8'h70);
    rx_push(8'h71);
    chk("t3_count2", rx_count, 2);
    do_read(4'd5, 0, 8'h00, d, rid, rl, ok);
    chk("t3_ok0", ok, 1); chk("t3_rdata0", d, 8'h70);
    chk("t3_rid", rid, 4'd5); chk("t3_rlast", rl, 1);
    chk("t3_count1", rx_count, 1);
    do_read(4'd5, 1, 8'h72, d, rid, rl, ok);
    chk("t3_ok1", ok, 1); chk("t3_rdata1", d, 8'h71);
    chk("t3_count_pushpop", rx_count, 1);
    do_read(4'd5, 0, 8'h00, d, rid, rl, ok);
    chk("t3_rdata2", d, 8'h72);
    chk("t3_count0", rx_count, 0);

    // Read stall on empty FIFO: AR in cycle 0, RX byte in cycle 20
    @(negedge clk); io_arid = 4'd2; io_arvalid = 1;
    early = 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) io_arvalid = 0;
      if (io_rvalid) early = 1;
      if (k == 20) begin rx_valid = 1; rx_data = 8'h55; end
      if (k == 21) begin rx_valid = 0; chk("t4_count", rx_count, 1); end
    end
    chk("t4_no_early_r", early, 0);
    @(negedge clk);
    chk("t4_rvalid22", io_rvalid, 1);
    chk("t4_rdata", io_rdata, 8'h55);
    chk("t4_rid", io_rid, 4'd2);
    io_rready = 1;
    @(negedge clk); io_rready = 0;

    // FIFO full, held 17th byte, and in-order reads across pointer wrap
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rx_valid = 1; rx_data = 8'(8'h80 + i);
    end
    @(negedge clk); rx_data = 8'h90;
    chk("t5_full_count", rx_count, 16);
    chk("t5_full_ready", rx_ready, 0);
    @(negedge clk); @(negedge clk);
    chk("t5_hold_count", rx_count, 16);
    chk("t5_hold_ready", rx_ready, 0);
    fork
      begin : feeder
        int idx = 16;
        int guard = 0;
        while (idx < 20 && guard < 2000) begin
          if (rx_ready) begin @(posedge clk); idx++; end
          @(negedge clk); guard++;
          if (idx < 20) rx_data = 8'(8'h80 + idx);
          else rx_valid = 0;
        end
        rx_valid = 0;
      end
      begin : reader
        logic [7:0] rd;
        logic [3:0] rr;
        logic       rlst;
        bit         rok;
        for (int r = 0; r < 20; r++) begin
          do_read(4'd1, 0, 8'h00, rd, rr, rlst, rok);
          chk("t5_rok", rok, 1);
          chk("t5_rdata", rd, 32'h80 + r);
          if (r == 0) chk("t5_refill16", rx_count, 16);
        end
      end
    join
    @(negedge clk);
    chk("t5_drained", rx_count, 0);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) rx_push(8'(8'hA0 + i));
    chk("t6_count4", rx_count, 4);
    @(negedge clk); io_awid = 4'd9; io_awvalid = 1;
    @(negedge clk); io_awvalid = 0; io_wdata = 8'hB0; io_wlast = 0; io_wvalid = 1;
    @(negedge clk); io_wvalid = 0;
    chk("t6_txv_pre", tx_valid, 1);
    io_arid = 4'd4; io_arvalid = 1;
    @(negedge clk); io_arvalid = 0;
    @(negedge clk);
    chk("t6_rvalid_pre", io_rvalid, 1);
    #2 nrst = 1'b0;
    #1;
    chk("t6_txv", tx_valid, 0);
    chk("t6_bvalid", io_bvalid, 0);
    chk("t6_rvalid", io_rvalid, 0);
    chk("t6_count", rx_count, 0);
    @(negedge clk); nrst = 1'b1;
    @(negedge clk); io_awid = 4'd12; io_awvalid = 1; tx_ready = 1;
    chk("t6_awready", io_awready, 1);
    @(negedge clk); io_awvalid = 0; io_wdata = 8'hC3; io_wlast = 1; io_wvalid = 1;
    @(negedge clk); io_wvalid = 0; io_wlast = 0;
    chk("t6_txd", tx_data, 8'hC3);
    @(negedge clk);
    chk("t6_bvalid_new", io_bvalid, 1);
    chk("t6_bid_new", io_bid, 4'd12);
    io_bready = 1;
    @(negedge clk); io_bready = 0; tx_ready = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
